// File: rtl/ahb_fir_pkg.sv
// Shared types and constants for the AHB-attached FIR coefficient store.
package ahb_fir_pkg;

  localparam int AWIDTH   = 32;
  localparam int DWIDTH   = 32;
  localparam int BIT_PREC = 16;
  localparam int TAPS     = 16;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} ahb_slv_state_t;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/ahb_slv_resp.sv
// AHB-Lite slave response sequencer: inserts wait states or a two-cycle ERROR
// response. Outputs are registered and refer to the transfer in its data phase.
module ahb_slv_resp
  import ahb_fir_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic illegal,
  output logic hreadyout,
  output logic hresp,
  output logic complete
);

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_slv_state_t state_q;
  logic [3:0]     cnt_q;
  logic           hreadyout_q;
  logic           hresp_q;
  logic           complete_q;

  // A new address phase can only be taken while the previous data phase ends ready (IDLE or ERR2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        IDLE, ERR2: begin
          state_q     <= IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            if (illegal) begin
              state_q     <= ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              complete_q <= 1'b1;
            end else begin
              state_q     <= WAIT;
              cnt_q       <= CNT_LOAD;
              hreadyout_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            complete_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q     <= ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign complete  = complete_q;

endmodule

// File: rtl/ahb_coef_ram.sv
// AHB-Lite coefficient RAM: bus writes fill a shadow RAM, and a CTRL-requested
// commit copies it into the active FIR bank on a frame boundary.
module ahb_coef_ram
  import ahb_fir_pkg::*;
#(
  parameter int MEM_BYTE    = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hsel,
  input  logic [AWIDTH-1:0]              haddr,
  input  logic [2:0]                     hsize,
  input  logic                           hwrite,
  input  logic [1:0]                     htrans,
  input  logic [DWIDTH-1:0]              hwdata,
  input  logic                           hready,
  output logic                           hreadyout,
  output logic                           hresp,
  output logic [DWIDTH-1:0]              hrdata,
  input  logic                           frame_sync,
  output logic [TAPS-1:0][BIT_PREC-1:0]  fircoefs,
  output logic                           coef_upd
);

  localparam int AW        = $clog2(MEM_BYTE);
  localparam int WW        = AW - 2;
  localparam int MEM_WORDS = MEM_BYTE / 4;
  localparam logic [WW-1:0] CTRL_IDX = WW'(MEM_WORDS - 1);

  if (((MEM_BYTE & (MEM_BYTE - 1)) != 0) || (MEM_BYTE < 4 * (TAPS + 1))) begin : g_bad_mem_byte
    $error("ahb_coef_ram: MEM_BYTE must be a power of two and at least 4*(TAPS+1)");
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
    $error("ahb_coef_ram: WAIT_STATES must be in 0..15");
  end

  logic [DWIDTH-1:0] shadow_mem [MEM_WORDS-1];

  logic [AW-1:0]              addr_q, addr_d;
  logic [2:0]                 size_q, size_d;
  logic                       write_q, write_d;
  logic                       pending_q, pending_d;
  logic [CNT_W-1:0]           commit_cnt_q, commit_cnt_d;
  logic [TAPS-1:0][BIT_PREC-1:0] fircoefs_q, fircoefs_d;
  logic                       coef_upd_q, coef_upd_d;

  logic          accept, illegal, complete;
  logic          live_ctrl, is_ctrl, ram_we, ctrl_wr, commit;
  logic [WW-1:0] idx;
  logic [3:0]    be;
  logic [DWIDTH-1:0] rd_word;
  logic          unused_bits;

  assign unused_bits = ^{haddr[AWIDTH-1:AW], htrans[0]};

  // Address-phase decode works on the live bus so the response FSM can react at the sampling edge.
  always_comb begin
    accept    = hready & hsel & htrans[1];
    live_ctrl = (haddr[AW-1:2] == CTRL_IDX);
    illegal   = (hsize > 3'd2)
              | ((hsize == 3'd1) & haddr[0])
              | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
              | (live_ctrl & (hsize != 3'd2));
  end

  ahb_slv_resp #(.WAIT_STATES(WAIT_STATES)) u_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .illegal   (illegal),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .complete  (complete)
  );

  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    if (hready) begin
      addr_d  = haddr[AW-1:0];
      size_d  = hsize;
      write_d = hwrite;
    end

    idx     = addr_q[AW-1:2];
    is_ctrl = (idx == CTRL_IDX);
    ram_we  = complete & write_q & ~is_ctrl;
    ctrl_wr = complete & write_q & is_ctrl;

    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase

    if (is_ctrl) rd_word = {16'b0, commit_cnt_q, 7'b0, pending_q};
    else         rd_word = shadow_mem[idx];
    hrdata = (complete & ~write_q) ? rd_word : '0;

    // A commit that coincides with a COMMIT write consumes the old request; the write is then a no-op.
    commit       = pending_q & frame_sync;
    pending_d    = pending_q;
    commit_cnt_d = commit_cnt_q;
    fircoefs_d   = fircoefs_q;
    coef_upd_d   = commit;
    if (commit) begin
      pending_d    = 1'b0;
      commit_cnt_d = commit_cnt_q + 1'b1;
      for (int i = 0; i < TAPS; i++) begin
        fircoefs_d[i] = shadow_mem[WW'(i)][BIT_PREC-1:0];
      end
    end else if (ctrl_wr & hwdata[CTRL_COMMIT_BIT]) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      pending_q    <= 1'b0;
      commit_cnt_q <= '0;
      fircoefs_q   <= '0;
      coef_upd_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      size_q       <= size_d;
      write_q      <= write_d;
      pending_q    <= pending_d;
      commit_cnt_q <= commit_cnt_d;
      fircoefs_q   <= fircoefs_d;
      coef_upd_q   <= coef_upd_d;
    end
  end

  // Shadow RAM is deliberately not reset so coefficients survive a bus reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) shadow_mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign fircoefs = fircoefs_q;
  assign coef_upd = coef_upd_q;

endmodule
